uart_tx_strobed: RTL and testbench
==================================

Name: uart_tx_strobed

Overview:
Serial UART transmitter paced by an external single-cycle baud strobe, normally the output of the team's strobe divider running at the baud rate. Accepts parallel words over a valid/ready handshake, serialises them LSB-first with start, optional parity and stop bits, and drives the TX line. It sits directly downstream of the strobe divider and consumes its strobe as the only timing source.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9, elaborate-time $error outside it.
PARITY, 0, 0 = none, 1 = odd, 2 = even; any other value raises $error.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2, otherwise $error.

Ports:
i_clk  input  1  system clock; all state changes on posedge.
i_reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
i_baud_strobe  input  1  one-cycle pulse per bit period; strobe period is always >= 2 clocks.
i_data  input  DATA_BITS  word to send; sampled only on handshake.
i_valid  input  1  upstream has a word.
o_ready  output  1  block can accept a word (registered).
o_tx  output  1  serial line, idle high (registered).
o_busy  output  1  high from handshake until frame complete.

Behaviour:
- Reset (asynchronous on i_reset_n low): state IDLE, o_tx=1, o_ready=0, o_busy=0, shift register and counters 0. o_ready rises on the first posedge after reset release.
- Handshake: transfer occurs on a posedge with i_valid && o_ready. i_data is captured into the shift register, o_ready goes 0 and o_busy goes 1 on the next cycle. o_ready is 1 only in IDLE. i_valid without o_ready is ignored; i_data may change freely.
- States: IDLE, ARMED, START, DATA, PARITY, STOP. All transitions other than IDLE->ARMED happen only on cycles with i_baud_strobe=1. o_tx is registered and updates on the same edge as the transition.
  - IDLE -> ARMED on handshake. A strobe in the handshake cycle is ignored. A strobe in IDLE has no effect.
  - ARMED -> START on strobe; o_tx<=0.
  - START -> DATA on strobe; o_tx<=bit0, bit counter=0.
  - DATA: on each strobe, shift and output the next bit. After DATA_BITS bits, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: o_tx<=XOR of data bits (even), inverted for odd.
  - STOP: o_tx<=1 for STOP_BITS strobe periods. The strobe ending the last stop bit moves to IDLE, o_busy<=0, o_ready<=1.
- Each line level lasts exactly one strobe interval. The line therefore changes 1 clock after a strobe edge, consistently.
- Back-to-back frames: if i_valid is high when returning to IDLE, the handshake happens the next cycle. The next start bit begins on the following strobe, so there is no extra idle beyond the stop bit(s). This requires a strobe period >= 2.
- Reset mid-frame: frame is abandoned, o_tx returns high immediately (asynchronous), no partial frame resumes.
- Bit counter width: $clog2(DATA_BITS+1). Stop counter: 1 bit.
- FORMAL block:
  - o_ready implies state==IDLE.
  - o_tx==1 in IDLE/ARMED/STOP; o_tx==0 in START.
  - o_tx is stable on any cycle after a non-strobe cycle, except async reset.
  - Cover a complete frame.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PARITY_NONE, PARITY_ODD, PARITY_EVEN).
  - tx_state_e enum of the six states.
  - Constants UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0.
- No sub-module. The strobe divider is instantiated by the parent, not inside this block, so one divider can feed TX and RX.

Test Plan:
- Defaults, strobe every 4 clocks, send 0xA5 -> o_tx over successive strobe intervals: 0,1,0,1,0,0,1,0,1,1. o_busy high for 10 intervals, then o_ready=1.
- PARITY=2, send 0xA5 -> parity bit 0. PARITY=1, send 0xA5 -> parity bit 1. PARITY=2, send 0x01 -> parity bit 1. STOP_BITS=2 -> two high intervals before o_ready.
- i_valid held high with 0x00 then 0xFF, strobe every 2 clocks -> second start bit begins exactly one interval after the first stop bit, with no gap. o_ready pulses for 1 cycle between frames.
- Strobe coincident with the handshake cycle -> ignored. Start bit begins at the next strobe, not the coincident one.
- Assert i_reset_n=0 mid-DATA (after bit 3) -> o_tx=1 immediately. After release, o_ready=1 one cycle later; a new word 0x3C transmits correctly.
- DATA_BITS=5, send 0x1F -> 0,1,1,1,1,1,1. Input bits above bit 4 are absent by width.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the transmit/receive slice.
package uart_pkg;

    // Parity selection, numerically matching the PARITY parameter encoding.
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    // Transmitter frame states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_strobed.sv
// UART transmitter paced by an external one-cycle baud strobe.
// Words are accepted over valid/ready, then sent LSB-first with a start bit,
// optional parity bit and one or two stop bits. Every line level is held for
// exactly one strobe interval; the line changes on the clock edge that sees
// the strobe.
module uart_tx_strobed
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_baud_strobe,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int                 CNT_W       = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP   = 1'(STOP_BITS - 1);
    localparam parity_e            PARITY_MODE = parity_e'(PARITY[1:0]);
    localparam bit                 HAS_PARITY  = (PARITY_MODE != PARITY_NONE);
    localparam logic               ODD_PARITY  = (PARITY_MODE == PARITY_ODD);

    // Reject illegal configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_strobed: DATA_BITS=%0d outside 5..9", DATA_BITS);
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_strobed: PARITY=%0d not in {0,1,2}", PARITY);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_strobed: STOP_BITS=%0d not in {1,2}", STOP_BITS);
    end

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 parity_acc;
    logic                 tx;
    logic                 ready;
    logic                 busy;

    // Frame sequencer: state, shift register, counters and registered outputs.
    // ready is only ever set in S_IDLE, so valid && ready alone is the handshake.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_acc <= 1'b0;
            tx         <= UART_IDLE_LEVEL;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready && i_valid) begin
                        // A strobe coinciding with the handshake is deliberately ignored.
                        state      <= S_ARMED;
                        shift      <= i_data;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        parity_acc <= 1'b0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                    end
                end

                S_ARMED: begin
                    if (i_baud_strobe) begin
                        state <= S_START;
                        tx    <= UART_START_LEVEL;
                    end
                end

                S_START: begin
                    if (i_baud_strobe) begin
                        state      <= S_DATA;
                        tx         <= shift[0];
                        parity_acc <= shift[0];
                        shift      <= shift >> 1;
                        bit_cnt    <= '0;
                    end
                end

                S_DATA: begin
                    if (i_baud_strobe) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (HAS_PARITY) begin
                                state <= S_PARITY;
                                tx    <= parity_acc ^ ODD_PARITY;
                            end else begin
                                state    <= S_STOP;
                                tx       <= UART_IDLE_LEVEL;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            tx         <= shift[0];
                            parity_acc <= parity_acc ^ shift[0];
                            shift      <= shift >> 1;
                            bit_cnt    <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (i_baud_strobe) begin
                        state    <= S_STOP;
                        tx       <= UART_IDLE_LEVEL;
                        stop_cnt <= 1'b0;
                    end
                end

                S_STOP: begin
                    if (i_baud_strobe) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    tx    <= UART_IDLE_LEVEL;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx    = tx;
    assign o_ready = ready;
    assign o_busy  = busy;

`ifdef FORMAL
    a_ready_in_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_ready |-> state == S_IDLE);

    a_tx_high: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (state inside {S_IDLE, S_ARMED, S_STOP}) |-> o_tx == UART_IDLE_LEVEL);

    a_tx_start_low: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        state == S_START |-> o_tx == UART_START_LEVEL);

    a_tx_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !i_baud_strobe |=> $stable(o_tx));

    c_full_frame: cover property (@(posedge i_clk) disable iff (!i_reset_n)
        state == S_STOP && i_baud_strobe && stop_cnt == LAST_STOP);
`endif

endmodule

// File: tb/tb_uart_tx_strobed.sv
// Directed bench for uart_tx_strobed: five configurations sharing clock,
// reset and baud strobe, each with its own handshake and outputs.
// Index map: 0 default, 1 even parity, 2 odd parity, 3 two stop bits, 4 five data bits.
module tb_uart_tx_strobed;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strobe;
    logic       valid [5];
    logic [7:0] data  [5];
    logic       tx    [5];
    logic       ready [5];
    logic       busy  [5];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_strobed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
        .i_clk(clk), .i_reset_n(rst_n), .i_baud_strobe(strobe),
        .i_data(data[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]));

    uart_tx_strobed #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .i_clk(clk), .i_reset_n(rst_n), .i_baud_strobe(strobe),
        .i_data(data[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]));

    uart_tx_strobed #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .i_clk(clk), .i_reset_n(rst_n), .i_baud_strobe(strobe),
        .i_data(data[2]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]));

    uart_tx_strobed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_baud_strobe(strobe),
        .i_data(data[3]), .i_valid(valid[3]),
        .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]));

    uart_tx_strobed #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_five (
        .i_clk(clk), .i_reset_n(rst_n), .i_baud_strobe(strobe),
        .i_data(data[4][4:0]), .i_valid(valid[4]),
        .o_ready(ready[4]), .o_tx(tx[4]), .o_busy(busy[4]));

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Drive the strobe for the next posedge and move to the following negedge.
    task automatic tick(input logic s);
        strobe = s;
        @(negedge clk);
    endtask

    // Wait (bounded) for ready, then complete one handshake with word d.
    task automatic do_handshake(input int k, input logic [7:0] d, input logic hs_strobe);
        int n;
        n = 0;
        data[k]  = d;
        valid[k] = 1'b1;
        strobe   = 1'b0;
        while (ready[k] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("k%0d_hs_ready_seen", k), ready[k], 1'b1);
        tick(hs_strobe);
        valid[k] = 1'b0;
        strobe   = 1'b0;
        check($sformatf("k%0d_hs_ready_drop", k), ready[k], 1'b0);
        check($sformatf("k%0d_hs_busy_rise", k), busy[k], 1'b1);
        check($sformatf("k%0d_hs_armed_line", k), tx[k], 1'b1);
    endtask

    // Issue n_run strobes; pattern holds the n line levels, first-sent bit leftmost.
    // Strobe n+1 (if issued) ends the last stop bit.
    task automatic run_frame(input int k, input int period, input int gap0,
                             input int n, input logic [15:0] pattern, input int n_run);
        logic prev;
        logic b;
        prev = 1'b1;
        for (int i = 0; i < n_run; i++) begin
            repeat ((i == 0) ? gap0 : period - 1) tick(1'b0);
            check($sformatf("k%0d_hold%0d", k, i), tx[k], prev);
            tick(1'b1);
            if (i < n) begin
                b = pattern[n - 1 - i];
                check($sformatf("k%0d_line%0d", k, i), tx[k], b);
                check($sformatf("k%0d_busy%0d", k, i), busy[k], 1'b1);
                check($sformatf("k%0d_ready%0d", k, i), ready[k], 1'b0);
                prev = b;
            end else begin
                check($sformatf("k%0d_end_line", k), tx[k], 1'b1);
                check($sformatf("k%0d_end_busy", k), busy[k], 1'b0);
                check($sformatf("k%0d_end_ready", k), ready[k], 1'b1);
            end
        end
        strobe = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        strobe = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset state on every configuration.
        for (int k = 0; k < 5; k++) begin
            check($sformatf("k%0d_rst_tx", k), tx[k], 1'b1);
            check($sformatf("k%0d_rst_ready", k), ready[k], 1'b0);
            check($sformatf("k%0d_rst_busy", k), busy[k], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", ready[0], 1'b1);
        check("rel_busy", busy[0], 1'b0);

        // Default 8N1, 0xA5, strobe every 4 clocks.
        do_handshake(0, 8'hA5, 1'b0);
        run_frame(0, 4, 3, 10, 16'b0101001011, 11);

        // Even parity 0xA5 -> parity 0.
        do_handshake(1, 8'hA5, 1'b0);
        run_frame(1, 3, 2, 11, 16'b01010010101, 12);

        // Odd parity 0xA5 -> parity 1.
        do_handshake(2, 8'hA5, 1'b0);
        run_frame(2, 3, 2, 11, 16'b01010010111, 12);

        // Even parity 0x01 -> parity 1.
        do_handshake(1, 8'h01, 1'b0);
        run_frame(1, 3, 2, 11, 16'b01000000011, 12);

        // Two stop bits: two high intervals before ready.
        do_handshake(3, 8'hA5, 1'b0);
        run_frame(3, 3, 2, 11, 16'b01010010111, 12);

        // Strobe on the handshake cycle is ignored; 0x96.
        do_handshake(0, 8'h96, 1'b1);
        run_frame(0, 4, 3, 10, 16'b0011010011, 11);

        // Back-to-back with valid held, strobe every 2 clocks: 0x00 then 0xFF.
        do_handshake(0, 8'h00, 1'b0);
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        run_frame(0, 2, 1, 10, 16'b0000000001, 11);
        tick(1'b0);
        check("b2b_ready_pulse_end", ready[0], 1'b0);
        check("b2b_busy_again", busy[0], 1'b1);
        check("b2b_line_high", tx[0], 1'b1);
        valid[0] = 1'b0;
        run_frame(0, 2, 0, 10, 16'b0111111111, 11);

        // Reset mid-DATA after bit 3 of 0xA5 (bit 3 is 0).
        do_handshake(0, 8'hA5, 1'b0);
        run_frame(0, 4, 3, 10, 16'b0101001011, 5);
        tick(1'b0);
        check("pre_reset_line", tx[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx[0], 1'b1);
        check("async_rst_busy", busy[0], 1'b0);
        check("async_rst_ready", ready[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerel_ready", ready[0], 1'b1);
        check("rerel_tx", tx[0], 1'b1);
        do_handshake(0, 8'h3C, 1'b0);
        run_frame(0, 4, 3, 10, 16'b0001111001, 11);

        // Five data bits; upper input bits are not connected.
        do_handshake(4, 8'hFF, 1'b0);
        run_frame(4, 2, 1, 7, 16'b0111111, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
